// File: rtl/alu_result_reader.sv
// Streams words out of the result RAM over valid/ready through a 4-entry buffer.
// Optional running-XOR checksum output enabled by defining ALU_READER_CHECKSUM_EN.
module alu_result_reader #(
  parameter int unsigned width_p      = 8,
  parameter int unsigned addr_width_p = width_p + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    start_i,
  input  logic [addr_width_p-1:0] base_addr_i,
  input  logic [addr_width_p:0]   count_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ram_ce_o,
  output logic [addr_width_p-1:0] ram_addr_o,
  output logic                    ram_we_o,
  output logic [width_p-1:0]      ram_wd_o,
  output logic [width_p-1:0]      ram_w_mask_o,
  input  logic [width_p-1:0]      ram_rd_i,
  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
`ifdef ALU_READER_CHECKSUM_EN
  output logic [width_p-1:0]      checksum_o,
`endif
  input  logic                    ready_i
);

  localparam int unsigned Depth = 4;
  localparam logic [addr_width_p:0]   CntOne  = 1;
  localparam logic [addr_width_p-1:0] AddrOne = 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic [addr_width_p:0]   issue_left_q, issue_left_d;
  logic [addr_width_p:0]   xfer_left_q, xfer_left_d;
  logic                    ce_q, ce_d;
  logic [addr_width_p-1:0] ram_addr_q, ram_addr_d;
  logic                    rd_pend_q;
  logic [width_p-1:0]      mem_q [Depth];
  logic [1:0]              wr_ptr_q, rd_ptr_q;
  logic [2:0]              occ_q;
  logic [2:0]              pending;
  logic                    push, pop, accept_start;

  assign push   = rd_pend_q;
  assign v_o    = (occ_q != 3'd0);
  assign pop    = v_o & ready_i;
  assign data_o = mem_q[rd_ptr_q];

  // Words already buffered plus reads that will still land; issuing must never overrun the FIFO.
  assign pending = occ_q + {2'b00, ce_q} + {2'b00, rd_pend_q};

  assign busy_o       = (state_q == StIssue) || (state_q == StDrain);
  assign done_o       = (state_q == StDone);
  assign ram_ce_o     = ce_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_we_o     = 1'b0;
  assign ram_wd_o     = '0;
  assign ram_w_mask_o = '0;
  assign accept_start = (state_q == StIdle) && start_i;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    xfer_left_d  = xfer_left_q;
    ce_d         = 1'b0;
    ram_addr_d   = ram_addr_q;
    if (pop) begin
      xfer_left_d = xfer_left_q - CntOne;
    end
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (count_i == '0) begin
            state_d = StDone;
          end else begin
            state_d      = StIssue;
            ce_d         = 1'b1;
            ram_addr_d   = base_addr_i;
            addr_d       = base_addr_i + AddrOne;
            issue_left_d = count_i - CntOne;
            xfer_left_d  = count_i;
          end
        end
      end
      StIssue: begin
        if (issue_left_q == '0) begin
          state_d = StDrain;
        end else if (pending < 3'd4) begin
          ce_d         = 1'b1;
          ram_addr_d   = addr_q;
          addr_d       = addr_q + AddrOne;
          issue_left_d = issue_left_q - CntOne;
        end
      end
      StDrain: begin
        if (pop && (xfer_left_q == CntOne)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      issue_left_q <= '0;
      xfer_left_q  <= '0;
      ce_q         <= 1'b0;
      ram_addr_q   <= '0;
      rd_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      xfer_left_q  <= xfer_left_d;
      ce_q         <= ce_d;
      ram_addr_q   <= ram_addr_d;
      rd_pend_q    <= ce_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= ram_rd_i;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + 3'd1;
        2'b01:   occ_q <= occ_q - 3'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifdef ALU_READER_CHECKSUM_EN
  logic [width_p-1:0] checksum_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      checksum_q <= '0;
    end else if (accept_start) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q ^ data_o;
    end
  end

  assign checksum_o = checksum_q;
`else
  logic unused_start;
  assign unused_start = accept_start;
`endif

endmodule

// File: tb/tb_alu_result_reader.sv
// Scoreboard bench for alu_result_reader: bursts push expected words, a negedge monitor pops.
module tb_alu_result_reader;
  localparam int W  = 8;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   count = '0;
  logic          busy, done, ram_ce, ram_we, v;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wd, ram_w_mask, data;
  logic [W-1:0]  ram_rd = '0;
`ifdef ALU_READER_CHECKSUM_EN
  logic [W-1:0]  checksum;
`endif

  logic [W-1:0]  ram_mem [512];
  logic [W-1:0]  exp_q [$];
  logic [AW-1:0] got_addrs [$];
  int tests = 0;
  int fails = 0;
  int issued = 0;
  int popped = 0;
  int nce_snap = 0;
  logic          held_v = 1'b0;
  logic [W-1:0]  held_data = '0;

  alu_result_reader dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .start_i      (start),
    .base_addr_i  (base),
    .count_i      (count),
    .busy_o       (busy),
    .done_o       (done),
    .ram_ce_o     (ram_ce),
    .ram_addr_o   (ram_addr),
    .ram_we_o     (ram_we),
    .ram_wd_o     (ram_wd),
    .ram_w_mask_o (ram_w_mask),
    .ram_rd_i     (ram_rd),
    .v_o          (v),
    .data_o       (data),
`ifdef ALU_READER_CHECKSUM_EN
    .checksum_o   (checksum),
`endif
    .ready_i      (ready)
  );

  always #5 clk = ~clk;

  // One-cycle-latency single-port RAM model.
  always @(posedge clk) begin
    if (ram_ce) ram_rd <= ram_mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer, checks stall stability and buffer bound.
  always @(negedge clk) begin
    if (!reset_n) begin
      held_v = 1'b0;
      issued = 0;
      popped = 0;
    end else begin
      if (held_v) begin
        check("stall_hold_v", {31'd0, v}, 32'd1);
        check("stall_hold_data", {24'd0, data}, {24'd0, held_data});
      end
      if (ram_ce) begin
        issued++;
        check("outstanding_le4", {31'd0, (issued - popped) <= 4}, 32'd1);
      end
      if (v && ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected none", data);
        end else begin
          check("data_order", {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
        popped++;
      end
      held_v    = v && !ready;
      held_data = data;
    end
  end

  // rmode: 0 ready high, 1 random ready, 2 ready low in cycles 3..10.
  task automatic burst(input int b, input int n, input int rmode, input bit junk,
                       output int first_v, output int done_c, output int nce,
                       output int busy_seen);
    logic [W-1:0] cks;
    int limit;
    cks = '0;
    got_addrs.delete();
    first_v   = 0;
    done_c    = 0;
    nce       = 0;
    busy_seen = 0;
    nce_snap  = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ram_mem[(b + i) % 512]);
      cks = cks ^ ram_mem[(b + i) % 512];
    end
    @(posedge clk); #1;
    start = 1'b1;
    base  = AW'(b);
    count = (AW + 1)'(n);
    limit = 6 * n + 20;
    for (int c = 1; c <= limit && done_c == 0; c++) begin
      @(posedge clk); #1;
      start = junk && ($urandom_range(3) == 0);
      if (start) begin
        base  = AW'($urandom_range(511));
        count = (AW + 1)'($urandom_range(20, 1));
      end
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = ($urandom_range(1) == 1);
        default: ready = !(c >= 3 && c <= 10);
      endcase
      @(negedge clk);
      if (ram_ce) begin
        nce++;
        got_addrs.push_back(ram_addr);
      end
      if (busy) busy_seen++;
      if (v && first_v == 0) first_v = c;
      if (done) done_c = c;
      if (c == 10) nce_snap = nce;
    end
    start = 1'b0;
    if (done_c == 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done_o expected within %0d cycles", limit);
    end
    check("queue_drained", exp_q.size(), 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_not_busy", {31'd0, busy}, 32'd0);
`ifdef ALU_READER_CHECKSUM_EN
    check("checksum_running_xor", {24'd0, checksum}, {24'd0, cks});
`endif
  endtask

  initial begin
    int fv, dc, nce, bs;
    for (int i = 0; i < 512; i++) ram_mem[i] = W'($urandom_range(255));
    for (int i = 0; i < 4; i++) ram_mem[i] = W'(8'h10 + i);
    ram_mem[300] = 8'h0F;
    ram_mem[301] = 8'hF0;
    ram_mem[302] = 8'h55;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ce", {31'd0, ram_ce}, 32'd0);
    check("rst_addr", {23'd0, ram_addr}, 32'd0);
    check("rst_v", {31'd0, v}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    check("ram_we_zero", {31'd0, ram_we}, 32'd0);
    check("ram_wd_mask_zero", {16'd0, ram_wd, ram_w_mask}, 32'd0);
    reset_n = 1'b1;

    // Basic burst: 0x10..0x13, first word in cycle 3, done in cycle 7.
    burst(0, 4, 0, 1'b0, fv, dc, nce, bs);
    check("basic_first_v_cycle", fv, 32'd3);
    check("basic_done_cycle", dc, 32'd7);
    check("basic_ce_count", nce, 32'd4);

    // Address wrap 510, 511, 0, 1.
    burst(510, 4, 0, 1'b0, fv, dc, nce, bs);
    check("wrap_ce_count", got_addrs.size(), 32'd4);
    if (got_addrs.size() == 4) begin
      check("wrap_addr0", {23'd0, got_addrs[0]}, 32'd510);
      check("wrap_addr1", {23'd0, got_addrs[1]}, 32'd511);
      check("wrap_addr2", {23'd0, got_addrs[2]}, 32'd0);
      check("wrap_addr3", {23'd0, got_addrs[3]}, 32'd1);
    end

    // Back-pressure: ready low cycles 3..10, issue stalls at 4.
    burst(40, 8, 2, 1'b0, fv, dc, nce, bs);
    check("stall_ce_by_cycle10", nce_snap, 32'd4);
    check("stall_ce_total", nce, 32'd8);

    // Zero-length burst.
    burst(7, 0, 0, 1'b0, fv, dc, nce, bs);
    check("zero_done_cycle", dc, 32'd1);
    check("zero_ce_count", nce, 32'd0);
    check("zero_no_v", fv, 32'd0);
    check("zero_never_busy", bs, 32'd0);

    // Reset in cycle 4 of a 16-word burst, then a fresh burst must show no stale words.
    for (int i = 0; i < 16; i++) exp_q.push_back(ram_mem[100 + i]);
    @(posedge clk); #1;
    start = 1'b1; base = 9'd100; count = 10'd16; ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ce", {31'd0, ram_ce}, 32'd0);
    check("mid_rst_addr", {23'd0, ram_addr}, 32'd0);
    check("mid_rst_v", {31'd0, v}, 32'd0);
    check("mid_rst_data", {24'd0, data}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
`ifdef ALU_READER_CHECKSUM_EN
    check("mid_rst_checksum", {24'd0, checksum}, 32'd0);
`endif
    exp_q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    burst(200, 6, 0, 1'b0, fv, dc, nce, bs);
    check("post_rst_done_cycle", dc, 32'd9);

    // Checksum words 0x0F ^ 0xF0 ^ 0x55.
    burst(300, 3, 0, 1'b0, fv, dc, nce, bs);
`ifdef ALU_READER_CHECKSUM_EN
    check("checksum_aa", {24'd0, checksum}, 32'h0000_00AA);
`endif

    // Full RAM sweep at full rate.
    burst(0, 512, 0, 1'b0, fv, dc, nce, bs);
    check("full_done_cycle", dc, 32'd515);
    check("full_ce_count", nce, 32'd512);

    // Random bursts with random back-pressure and ignored starts while busy.
    for (int t = 0; t < 15; t++) begin
      int nb;
      int nn;
      nb = $urandom_range(511);
      nn = $urandom_range(40, 1);
      burst(nb, nn, 1, 1'b1, fv, dc, nce, bs);
      check("rand_ce_count", nce, nn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
